// File: rtl/cart_rom_mapper_pkg.sv
// MSX cartridge mapper types, window constants and per-mapper bank reset values.
package MSX;

    typedef enum logic [3:0] {
        MAPPER_UNUSED     = 4'd0,
        MAPPER_NONE       = 4'd1,
        MAPPER_LINEAR     = 4'd2,
        MAPPER_ASCII8     = 4'd3,
        MAPPER_ASCII16    = 4'd4,
        MAPPER_KONAMI     = 4'd5,
        MAPPER_KONAMI_SCC = 4'd6
    } mapper_typ_t;

    typedef struct packed {
        logic [26:0] addr;
        logic [15:0] size;
        logic        ro;
    } lookup_RAM_t;

    localparam int BANK_REG_W = 8;

    localparam logic [15:0] WIN0_BASE = 16'h4000;
    localparam logic [15:0] WIN1_BASE = 16'h6000;
    localparam logic [15:0] WIN2_BASE = 16'h8000;
    localparam logic [15:0] WIN3_BASE = 16'hA000;

    typedef logic [3:0][BANK_REG_W-1:0] bank_regs_t;

    // Index 0 is window W0; non-register mappers never read the banks.
    function automatic bank_regs_t mapper_reset_banks(input mapper_typ_t m);
        bank_regs_t b;
        case (m)
            MAPPER_ASCII8:  b = {8'd0, 8'd0, 8'd0, 8'd0};
            MAPPER_ASCII16: b = {8'd1, 8'd0, 8'd1, 8'd0};
            default:        b = {8'd3, 8'd2, 8'd1, 8'd0};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cart_bank_wr_decode.sv
// Combinational decode of Z80 writes into bank-register write enables and data.
// KONAMI_SCC register map only exists when CART_KONAMI_SCC_EN is defined.
module cart_bank_wr_decode
    import MSX::*;
#(
    parameter int BANK_W = 8
) (
    input  mapper_typ_t             mapper,
    input  logic [15:0]             addr,
    input  logic [7:0]              data,
    output logic [3:0]              we,
    output logic [3:0][BANK_W-1:0]  bank_data
);

    logic [4:0] page;
    logic [3:0] konami_we;
    logic       unused_addr;

    assign page        = addr[15:11];
    assign unused_addr = ^addr[10:0];

    always_comb begin
        konami_we = 4'b0000;
        if (addr[15:13] == WIN1_BASE[15:13]) konami_we[1] = 1'b1;
        if (addr[15:13] == WIN2_BASE[15:13]) konami_we[2] = 1'b1;
        if (addr[15:13] == WIN3_BASE[15:13]) konami_we[3] = 1'b1;
    end

    always_comb begin
        we = 4'b0000;
        for (int i = 0; i < 4; i++) bank_data[i] = BANK_W'(data);
        case (mapper)
            MAPPER_ASCII8: begin
                case (page)
                    5'b01100: we[0] = 1'b1;
                    5'b01101: we[1] = 1'b1;
                    5'b01110: we[2] = 1'b1;
                    5'b01111: we[3] = 1'b1;
                    default:  we    = 4'b0000;
                endcase
            end
            MAPPER_ASCII16: begin
                // A 16 KiB bank spans two consecutive 8 KiB pages.
                bank_data[0] = BANK_W'({data[6:0], 1'b0});
                bank_data[1] = BANK_W'({data[6:0], 1'b1});
                bank_data[2] = BANK_W'({data[6:0], 1'b0});
                bank_data[3] = BANK_W'({data[6:0], 1'b1});
                if (page == 5'b01100) we = 4'b0011;
                if (page == 5'b01110) we = 4'b1100;
            end
            MAPPER_KONAMI: we = konami_we;
            MAPPER_KONAMI_SCC: begin
`ifdef CART_KONAMI_SCC_EN
                case (page)
                    5'b01010: we[0] = 1'b1;
                    5'b01110: we[1] = 1'b1;
                    5'b10010: we[2] = 1'b1;
                    5'b10110: we[3] = 1'b1;
                    default:  we    = 4'b0000;
                endcase
`else
                we = konami_we;
`endif
            end
            default: we = 4'b0000;
        endcase
    end

endmodule

// File: rtl/cart_rom_mapper.sv
// Cartridge ROM bank-switching stage: bank register writes and CPU-to-SDRAM address translation.
// Optional SCC register window is enabled by defining CART_KONAMI_SCC_EN.
module cart_rom_mapper
    import MSX::*;
#(
    parameter int BANK_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  mapper_typ_t mapper,
    input  lookup_RAM_t lookup,
    output logic [26:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_valid,
    output logic        scc_sel
);

    logic [3:0][BANK_W-1:0] banks;
    logic [3:0][BANK_W-1:0] bank_data;
    logic [3:0]             we;
    bank_regs_t             rst_banks;
    mapper_typ_t            mapper_q;
    logic                   wr_q;
    logic                   rd_q;
    logic                   wr_rise;
    logic                   rd_rise;
    logic [1:0]             win;
    logic                   in_rom;
    logic                   has_regs;
    logic [BANK_W-1:0]      bank_sel;
    logic [BANK_W-1:0]      bank_masked;
    logic [16:0]            mask_full;
    logic [BANK_W+12:0]     offset;
    logic [26:0]            addr_next;
    logic                   valid_next;
    logic                   scc_next;
    logic                   unused_bits;

    cart_bank_wr_decode #(.BANK_W(BANK_W)) u_wr_decode (
        .mapper    (mapper),
        .addr      (cpu_addr),
        .data      (cpu_dout),
        .we        (we),
        .bank_data (bank_data)
    );

    assign rst_banks = mapper_reset_banks(mapper);
    assign wr_rise   = cpu_wr & ~wr_q & cs;
    assign rd_rise   = cpu_rd & ~rd_q & cs & ~wr_rise;

    // 0x4000 -> W0 ... 0xA000 -> W3
    assign win      = {~cpu_addr[14], cpu_addr[13]};
    assign in_rom   = (cpu_addr >= WIN0_BASE) && (cpu_addr < (WIN3_BASE + 16'h2000));
    assign has_regs = (mapper == MAPPER_ASCII8) || (mapper == MAPPER_ASCII16) ||
                      (mapper == MAPPER_KONAMI) || (mapper == MAPPER_KONAMI_SCC);

    assign bank_sel    = has_regs ? banks[win] : BANK_W'(win);
    assign mask_full   = {lookup.size, 1'b0} - 17'd1;
    assign bank_masked = bank_sel & mask_full[BANK_W-1:0];
    assign offset      = {bank_masked, cpu_addr[12:0]};
    assign addr_next   = lookup.addr + 27'(offset);
    assign valid_next  = in_rom && (lookup.size != 16'd0) && (mapper != MAPPER_UNUSED);
    assign unused_bits = ^{mask_full, lookup.ro};

`ifdef CART_KONAMI_SCC_EN
    assign scc_next = (mapper == MAPPER_KONAMI_SCC) && (banks[2][5:0] == 6'h3F) &&
                      cs && (cpu_addr[15:11] == 5'b10011);
`else
    assign scc_next = 1'b0;
`endif

    // A mapper change reloads the banks and swallows any write in the same cycle.
    always_ff @(posedge clk) begin
        wr_q     <= cpu_wr;
        rd_q     <= cpu_rd;
        mapper_q <= mapper;
        if (reset) begin
            for (int i = 0; i < 4; i++) banks[i] <= BANK_W'(rst_banks[i]);
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_valid <= 1'b0;
            scc_sel   <= 1'b0;
        end else begin
            if (mapper != mapper_q) begin
                for (int i = 0; i < 4; i++) banks[i] <= BANK_W'(rst_banks[i]);
            end else if (wr_rise) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) banks[i] <= bank_data[i];
                end
            end
            mem_addr  <= addr_next;
            mem_valid <= valid_next;
            scc_sel   <= scc_next;
            mem_rd    <= rd_rise && valid_next && !scc_next;
        end
    end

endmodule

// File: tb/tb_cart_rom_mapper.sv
// Directed self-checking bench for cart_rom_mapper; expectations follow CART_KONAMI_SCC_EN.
module tb_cart_rom_mapper;
    import MSX::*;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic        cpu_rd;
    mapper_typ_t mapper;
    lookup_RAM_t lookup;
    logic [26:0] mem_addr;
    logic        mem_rd;
    logic        mem_valid;
    logic        scc_sel;

    int checks   = 0;
    int failures = 0;

    cart_rom_mapper #(.BANK_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .mapper    (mapper),
        .lookup    (lookup),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_valid (mem_valid),
        .scc_sel   (scc_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        cs = 1'b1; cpu_addr = a; cpu_dout = d; cpu_wr = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        cpu_wr = 1'b0; cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [15:0] a, output int pulses, output logic [26:0] addr0,
                           output logic valid0, output logic scc0);
        cs = 1'b1; cpu_addr = a; cpu_rd = 1'b1;
        @(posedge clk); #1;
        addr0 = mem_addr; valid0 = mem_valid; scc0 = scc_sel; pulses = int'(mem_rd);
        repeat (3) begin
            @(posedge clk); #1;
            pulses += int'(mem_rd);
        end
        cpu_rd = 1'b0; cs = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_mapper(input mapper_typ_t m);
        mapper = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        mapper = MAPPER_KONAMI; lookup.addr = 27'h0100000; lookup.size = 16'd8; lookup.ro = 1'b1;
        cs = 1'b1; cpu_addr = 16'h4000;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (mem_addr !== 27'h0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        if (mem_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        if (mem_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_valid got=%b exp=0", mem_valid); end
        if (scc_sel !== 1'b0) begin failures++; $display("[TB] FAIL reset_scc_sel got=%b exp=0", scc_sel); end
        cs = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_konami_read;
        int p; logic [26:0] a; logic v, s;
        do_read(16'hA123, p, a, v, s);
        checks += 3;
        if (p !== 1) begin failures++; $display("[TB] FAIL konami_pulses got=%0d exp=1", p); end
        if (a !== 27'h0106123) begin failures++; $display("[TB] FAIL konami_addr got=%h exp=0106123", a); end
        if (v !== 1'b1) begin failures++; $display("[TB] FAIL konami_valid got=%b exp=1", v); end
    endtask

    task automatic test_ascii8;
        int p; logic [26:0] a; logic v, s;
        set_mapper(MAPPER_ASCII8);
        do_write(16'h7800, 8'h05, 4);
        do_read(16'hA010, p, a, v, s);
        checks += 2;
        if (p !== 1) begin failures++; $display("[TB] FAIL ascii8_pulses got=%0d exp=1", p); end
        if (a !== 27'h010A010) begin failures++; $display("[TB] FAIL ascii8_b3_addr got=%h exp=010A010", a); end
        do_read(16'h4000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0100000) begin failures++; $display("[TB] FAIL ascii8_b0_addr got=%h exp=0100000", a); end
    endtask

    task automatic test_ascii16;
        int p; logic [26:0] a; logic v, s;
        lookup.size = 16'd4;
        set_mapper(MAPPER_ASCII16);
        do_read(16'h6000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0102000) begin failures++; $display("[TB] FAIL ascii16_reset_b1 got=%h exp=0102000", a); end
        do_write(16'h6000, 8'h07, 1);
        do_read(16'h4000, p, a, v, s);
        checks += 2;
        if (a !== 27'h010C000) begin failures++; $display("[TB] FAIL ascii16_b0_wrap got=%h exp=010C000", a); end
        if (p !== 1) begin failures++; $display("[TB] FAIL ascii16_pulses got=%0d exp=1", p); end
        do_read(16'h6000, p, a, v, s);
        checks += 1;
        if (a !== 27'h010E000) begin failures++; $display("[TB] FAIL ascii16_b1_wrap got=%h exp=010E000", a); end
        do_read(16'h8000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0100000) begin failures++; $display("[TB] FAIL ascii16_b2_kept got=%h exp=0100000", a); end
        lookup.size = 16'd8;
    endtask

    task automatic test_mapper_switch;
        int p; logic [26:0] a; logic v, s;
        set_mapper(MAPPER_KONAMI);
        mapper = MAPPER_ASCII8;
        cs = 1'b1; cpu_addr = 16'h6000; cpu_dout = 8'h09; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_wr = 1'b0; cs = 1'b0;
        @(posedge clk); #1;
        do_read(16'h4000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0100000) begin failures++; $display("[TB] FAIL switch_b0 got=%h exp=0100000", a); end
        do_read(16'h6000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0100000) begin failures++; $display("[TB] FAIL switch_b1 got=%h exp=0100000", a); end
        do_read(16'hA000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0100000) begin failures++; $display("[TB] FAIL switch_b3 got=%h exp=0100000", a); end
    endtask

    task automatic test_back_to_back;
        int p; logic [26:0] a; logic v, s;
        cs = 1'b1; cpu_addr = 16'h6800; cpu_dout = 8'h03; cpu_wr = 1'b1; cpu_rd = 1'b1;
        p = 0;
        repeat (3) begin
            @(posedge clk); #1;
            p += int'(mem_rd);
        end
        cpu_wr = 1'b0; cpu_rd = 1'b0; cs = 1'b0;
        @(posedge clk); #1;
        checks += 1;
        if (p !== 0) begin failures++; $display("[TB] FAIL rdwr_no_read got=%0d exp=0", p); end
        do_read(16'h6000, p, a, v, s);
        checks += 1;
        if (a !== 27'h0106000) begin failures++; $display("[TB] FAIL rdwr_write_won got=%h exp=0106000", a); end
    endtask

    task automatic test_invalid;
        int p; logic [26:0] a; logic v, s;
        do_read(16'hC000, p, a, v, s);
        checks += 2;
        if (v !== 1'b0) begin failures++; $display("[TB] FAIL c000_valid got=%b exp=0", v); end
        if (p !== 0) begin failures++; $display("[TB] FAIL c000_pulses got=%0d exp=0", p); end
        lookup.size = 16'd0;
        do_read(16'h4000, p, a, v, s);
        checks += 2;
        if (v !== 1'b0) begin failures++; $display("[TB] FAIL size0_valid got=%b exp=0", v); end
        if (p !== 0) begin failures++; $display("[TB] FAIL size0_pulses got=%0d exp=0", p); end
        lookup.size = 16'd8;
    endtask

    task automatic test_konami_scc;
        int p; logic [26:0] a; logic v, s;
        set_mapper(MAPPER_KONAMI_SCC);
        do_write(16'h9000, 8'h3F, 1);
        do_read(16'h9880, p, a, v, s);
        checks += 2;
`ifdef CART_KONAMI_SCC_EN
        if (s !== 1'b1) begin failures++; $display("[TB] FAIL scc_on_sel got=%b exp=1", s); end
        if (p !== 0) begin failures++; $display("[TB] FAIL scc_on_pulses got=%0d exp=0", p); end
`else
        if (s !== 1'b0) begin failures++; $display("[TB] FAIL scc_off_sel got=%b exp=0", s); end
        if (a !== 27'h011F880) begin failures++; $display("[TB] FAIL scc_off_addr got=%h exp=011F880", a); end
`endif
        do_write(16'h9000, 8'h02, 1);
        do_read(16'h9880, p, a, v, s);
        checks += 3;
        if (s !== 1'b0) begin failures++; $display("[TB] FAIL scc_b2_sel got=%b exp=0", s); end
        if (p !== 1) begin failures++; $display("[TB] FAIL scc_b2_pulses got=%0d exp=1", p); end
        if (a !== 27'h0105880) begin failures++; $display("[TB] FAIL scc_b2_addr got=%h exp=0105880", a); end
    endtask

    task automatic test_reset_cancel;
        int p;
        cs = 1'b1; cpu_addr = 16'h4000; cpu_rd = 1'b1; reset = 1'b1;
        p = 0;
        repeat (2) begin
            @(posedge clk); #1;
            p += int'(mem_rd);
        end
        cpu_rd = 1'b0; cs = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks += 1;
        if (p !== 0) begin failures++; $display("[TB] FAIL reset_cancel_pulses got=%0d exp=0", p); end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; cpu_addr = 16'h0; cpu_dout = 8'h0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        mapper = MAPPER_KONAMI; lookup = '0;
        @(posedge clk); #1;
        test_reset;
        test_konami_read;
        test_ascii8;
        test_ascii16;
        test_mapper_switch;
        test_back_to_back;
        test_invalid;
        test_konami_scc;
        test_reset_cancel;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
